// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/ready port between the MEM-stage sequencer (master) and data memory (slave).
interface mem_access_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: turns the EX/MEM load/store into a req/ready transaction, stalls the
// pipeline while it is outstanding, aligns/extends load data and flags illegal or timed-out accesses.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ex_mem_valid,
    input  logic                     ex_mem_read,
    input  logic                     ex_mem_write,
    input  logic [1:0]               ex_mem_size,
    input  logic                     ex_mem_unsigned,
    input  logic [31:0]              ex_mem_addr,
    input  logic [31:0]              ex_mem_wdata,
    mem_access_ctrl_if.master        mem,
    output logic                     stall_out,
    output logic                     mem_wb_en,
    output logic                     mem_wb_bubble,
    output logic [31:0]              load_data,
    output logic                     access_exc,
    output logic                     timeout_exc
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        timeout_flag;
    logic [1:0]  lane;
    logic [1:0]  size_q;
    logic        unsigned_q;

    logic        mem_op;
    logic        illegal;
    logic        start;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign mem_op  = ex_mem_valid & (ex_mem_read | ex_mem_write);
    assign illegal = (ex_mem_read & ex_mem_write)
                   | (ex_mem_size == 2'd3)
                   | ((ex_mem_size == 2'd1) & ex_mem_addr[0])
                   | ((ex_mem_size == 2'd2) & (ex_mem_addr[1:0] != 2'b00));
    assign start   = (state == IDLE) & mem_op & ~illegal;

    always_comb begin
        stall_out     = 1'b0;
        mem_wb_en     = 1'b0;
        mem_wb_bubble = 1'b0;
        access_exc    = 1'b0;
        timeout_exc   = 1'b0;
        case (state)
            IDLE: begin
                stall_out     = start;
                mem_wb_en     = ~start;
                mem_wb_bubble = mem_op & illegal;
                access_exc    = mem_op & illegal;
            end
            BUSY: stall_out = 1'b1;
            DONE: begin
                mem_wb_en     = 1'b1;
                mem_wb_bubble = timeout_flag;
                timeout_exc   = timeout_flag;
            end
            default: mem_wb_en = 1'b1;
        endcase
    end

    // Narrow stores are replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = ex_mem_wdata;
        case (ex_mem_size)
            2'd0: begin
                be_next    = 4'b0001 << ex_mem_addr[1:0];
                wdata_next = {4{ex_mem_wdata[7:0]}};
            end
            2'd1: begin
                be_next    = 4'b0011 << ex_mem_addr[1:0];
                wdata_next = {2{ex_mem_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (lane)
            2'd0:    byte_sel = mem.dmem_rdata[7:0];
            2'd1:    byte_sel = mem.dmem_rdata[15:8];
            2'd2:    byte_sel = mem.dmem_rdata[23:16];
            default: byte_sel = mem.dmem_rdata[31:24];
        endcase
        half_sel = lane[1] ? mem.dmem_rdata[31:16] : mem.dmem_rdata[15:0];
        case (size_q)
            2'd0:    load_ext = {{24{byte_sel[7] & ~unsigned_q}}, byte_sel};
            2'd1:    load_ext = {{16{half_sel[15] & ~unsigned_q}}, half_sel};
            default: load_ext = mem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            timeout_flag   <= 1'b0;
            lane           <= '0;
            size_q         <= '0;
            unsigned_q     <= 1'b0;
            mem.dmem_req   <= 1'b0;
            mem.dmem_we    <= 1'b0;
            mem.dmem_addr  <= '0;
            mem.dmem_wdata <= '0;
            mem.dmem_be    <= '0;
            load_data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem.dmem_req   <= 1'b1;
                        mem.dmem_we    <= ex_mem_write;
                        mem.dmem_addr  <= {ex_mem_addr[31:2], 2'b00};
                        mem.dmem_wdata <= wdata_next;
                        mem.dmem_be    <= be_next;
                        lane           <= ex_mem_addr[1:0];
                        size_q         <= ex_mem_size;
                        unsigned_q     <= ex_mem_unsigned;
                        wait_cnt       <= '0;
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    // Ready is checked first so a response on the last allowed cycle is not aborted.
                    if (mem.dmem_ready) begin
                        mem.dmem_req <= 1'b0;
                        if (!mem.dmem_we) begin
                            load_data <= load_ext;
                        end
                        state <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        mem.dmem_req <= 1'b0;
                        timeout_flag <= 1'b1;
                        state        <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DONE: begin
                    wait_cnt     <= '0;
                    timeout_flag <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: default-timeout instance (a) and TIMEOUT_CYCLES=4 instance (b)
// share stimulus; expected completions are queued at issue and popped when each DUT reaches DONE.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        v, rd, wr, uns;
    logic [1:0]  sz;
    logic [31:0] addr_in, wdata_in, rdata_in;
    logic        rdy;

    logic        stall_a, wb_en_a, bubble_a, acc_a, tmo_a;
    logic        stall_b, wb_en_b, bubble_b, acc_b, tmo_b;
    logic [31:0] ld_out_a, ld_out_b;

    int unsigned checks = 0;
    int unsigned failures = 0;

    typedef struct {
        logic [31:0] ld;
        logic        tmo;
        int unsigned len;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] ld_a = '0;
    logic [31:0] ld_b = '0;

    mem_access_ctrl_if bus_a();
    mem_access_ctrl_if bus_b();

    assign bus_a.dmem_ready = rdy;
    assign bus_a.dmem_rdata = rdata_in;
    assign bus_b.dmem_ready = rdy;
    assign bus_b.dmem_rdata = rdata_in;

    always #5 clk = ~clk;

    mem_access_ctrl dut_a (
        .clock(clk), .reset(rst),
        .ex_mem_valid(v), .ex_mem_read(rd), .ex_mem_write(wr), .ex_mem_size(sz),
        .ex_mem_unsigned(uns), .ex_mem_addr(addr_in), .ex_mem_wdata(wdata_in),
        .mem(bus_a.master),
        .stall_out(stall_a), .mem_wb_en(wb_en_a), .mem_wb_bubble(bubble_a),
        .load_data(ld_out_a), .access_exc(acc_a), .timeout_exc(tmo_a)
    );

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut_b (
        .clock(clk), .reset(rst),
        .ex_mem_valid(v), .ex_mem_read(rd), .ex_mem_write(wr), .ex_mem_size(sz),
        .ex_mem_unsigned(uns), .ex_mem_addr(addr_in), .ex_mem_wdata(wdata_in),
        .mem(bus_b.master),
        .stall_out(stall_b), .mem_wb_en(wb_en_b), .mem_wb_bubble(bubble_b),
        .load_data(ld_out_b), .access_exc(acc_b), .timeout_exc(tmo_b)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_illegal(input logic r, input logic w, input logic [1:0] s,
                                        input logic [31:0] a);
        if (r && w) return 1'b1;
        if (s == 2'd3) return 1'b1;
        if (s == 2'd1 && a[0]) return 1'b1;
        if (s == 2'd2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'd2) return 4'b1111;
        if (s == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
        case (a[1:0])
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] s, input logic [31:0] w);
        if (s == 2'd0) return {w[7:0], w[7:0], w[7:0], w[7:0]};
        if (s == 2'd1) return {w[15:0], w[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] s, input logic u,
                                             input logic [31:0] a, input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> (a[1:0] * 8);
        if (s == 2'd0) return u ? {24'h0, sh[7:0]} : 32'($signed(sh[7:0]));
        if (s == 2'd1) return u ? {16'h0, sh[15:0]} : 32'($signed(sh[15:0]));
        return d;
    endfunction

    // Called in an IDLE window; returns in the IDLE window following both DUTs' DONE.
    task automatic run_op(input logic i_rd, input logic i_wr, input logic [1:0] i_sz,
                          input logic i_uns, input logic [31:0] i_addr,
                          input logic [31:0] i_wdata, input logic [31:0] i_rdata,
                          input int unsigned ready_at);
        exp_t        ea, eb, pa, pb;
        logic        bad_op, bad_a, bad_b, done_a, done_b, post_b;
        logic [31:0] x_addr, x_wdata;
        logic [3:0]  x_be;
        int unsigned sta, stb, ra, rb;
        v = 1'b1; rd = i_rd; wr = i_wr; sz = i_sz; uns = i_uns;
        addr_in = i_addr; wdata_in = i_wdata; rdata_in = i_rdata; rdy = 1'b0;
        #1;
        bad_op = is_illegal(i_rd, i_wr, i_sz, i_addr);
        check1("issue_stall", stall_a, ~bad_op);
        check1("issue_wb_en", wb_en_a, bad_op);
        check1("issue_bubble", bubble_a, bad_op);
        check1("issue_access_exc_a", acc_a, bad_op);
        check1("issue_access_exc_b", acc_b, bad_op);
        check1("issue_no_req_yet", bus_a.dmem_req, 1'b0);
        if (bad_op) begin
            tick();
            v = 1'b0;
            #1;
            check1("illegal_no_req_a", bus_a.dmem_req, 1'b0);
            check1("illegal_no_req_b", bus_b.dmem_req, 1'b0);
            check1("illegal_no_stall", stall_a, 1'b0);
            return;
        end
        x_addr  = {i_addr[31:2], 2'b00};
        x_be    = exp_be(i_sz, i_addr);
        x_wdata = exp_wdata(i_sz, i_wdata);
        ea.len  = (ready_at != 0 && ready_at <= 255) ? ready_at : 255;
        eb.len  = (ready_at != 0 && ready_at <= 4) ? ready_at : 4;
        ea.tmo  = (ea.len != ready_at);
        eb.tmo  = (eb.len != ready_at);
        ea.ld   = (i_rd && !ea.tmo) ? exp_load(i_sz, i_uns, i_addr, i_rdata) : ld_a;
        eb.ld   = (i_rd && !eb.tmo) ? exp_load(i_sz, i_uns, i_addr, i_rdata) : ld_b;
        ld_a    = ea.ld;
        ld_b    = eb.ld;
        q_a.push_back(ea);
        q_b.push_back(eb);
        sta = 32'(stall_a); stb = 32'(stall_b);
        ra = 0; rb = 0;
        bad_a = 1'b0; bad_b = 1'b0; done_a = 1'b0; done_b = 1'b0; post_b = 1'b0;
        for (int unsigned c = 1; c <= 300 && !(done_a && done_b); c++) begin
            tick();
            v   = 1'b0;
            rdy = (c == ready_at);
            #1;
            if (!done_a) begin
                if (bus_a.dmem_req) begin
                    ra++;
                    sta += 32'(stall_a);
                    if (c == 1) begin
                        check1("busy_we", bus_a.dmem_we, i_wr);
                        check32("busy_addr", bus_a.dmem_addr, x_addr);
                        check32("busy_be", 32'(bus_a.dmem_be), 32'(x_be));
                        check32("busy_wdata", bus_a.dmem_wdata, x_wdata);
                    end
                    if (stall_a !== 1'b1 || wb_en_a !== 1'b0 || bus_a.dmem_we !== i_wr ||
                        bus_a.dmem_addr !== x_addr || bus_a.dmem_be !== x_be ||
                        bus_a.dmem_wdata !== x_wdata) bad_a = 1'b1;
                end else begin
                    done_a = 1'b1;
                    sta += 32'(stall_a);
                    pa = q_a.pop_front();
                    check32("a_req_cycles", ra, pa.len);
                    check32("a_stall_cycles", sta, pa.len + 1);
                    check1("a_busy_stable", bad_a, 1'b0);
                    check1("a_done_wb_en", wb_en_a, 1'b1);
                    check1("a_done_bubble", bubble_a, pa.tmo);
                    check1("a_timeout_exc", tmo_a, pa.tmo);
                    check32("a_load_data", ld_out_a, pa.ld);
                end
            end
            if (done_b && !post_b) begin
                post_b = 1'b1;
                check1("b_timeout_exc_one_cycle", tmo_b, 1'b0);
            end
            if (!done_b) begin
                if (bus_b.dmem_req) begin
                    rb++;
                    stb += 32'(stall_b);
                    if (bus_b.dmem_addr !== x_addr || bus_b.dmem_be !== x_be ||
                        wb_en_b !== 1'b0) bad_b = 1'b1;
                end else begin
                    done_b = 1'b1;
                    stb += 32'(stall_b);
                    pb = q_b.pop_front();
                    check32("b_req_cycles", rb, pb.len);
                    check32("b_stall_cycles", stb, pb.len + 1);
                    check1("b_busy_stable", bad_b, 1'b0);
                    check1("b_done_bubble", bubble_b, pb.tmo);
                    check1("b_timeout_exc", tmo_b, pb.tmo);
                    check32("b_load_data", ld_out_b, pb.ld);
                end
            end
        end
        check1("a_completed", done_a, 1'b1);
        check1("b_completed", done_b, 1'b1);
        rdy = 1'b0;
        tick();
        check1("a_timeout_exc_one_cycle", tmo_a, 1'b0);
        if (!post_b) check1("b_timeout_exc_one_cycle", tmo_b, 1'b0);
        check1("a_idle_req", bus_a.dmem_req, 1'b0);
    endtask

    initial begin
        rst = 1'b1; v = 1'b0; rd = 1'b0; wr = 1'b0; sz = 2'd0; uns = 1'b0;
        addr_in = '0; wdata_in = '0; rdata_in = '0; rdy = 1'b0;
        tick(); tick();
        check1("rst_req", bus_a.dmem_req, 1'b0);
        check1("rst_we", bus_a.dmem_we, 1'b0);
        check32("rst_be", 32'(bus_a.dmem_be), 32'h0);
        check32("rst_addr", bus_a.dmem_addr, 32'h0);
        check32("rst_wdata", bus_a.dmem_wdata, 32'h0);
        check32("rst_load_data", ld_out_a, 32'h0);
        check1("rst_timeout_exc", tmo_a, 1'b0);
        check1("rst_access_exc", acc_a, 1'b0);
        check1("rst_stall", stall_a, 1'b0);
        check1("rst_wb_en", wb_en_a, 1'b1);
        check1("rst_bubble", bubble_a, 1'b0);
        rst = 1'b0;
        tick();

        // ALU op: no penalty, no request
        v = 1'b1; rd = 1'b0; wr = 1'b0; sz = 2'd2; addr_in = 32'h0000_1003;
        for (int i = 0; i < 4; i++) begin
            #1;
            check1("alu_stall", stall_a, 1'b0);
            check1("alu_wb_en", wb_en_a, 1'b1);
            check1("alu_bubble", bubble_a, 1'b0);
            check1("alu_req", bus_a.dmem_req, 1'b0);
            tick();
        end
        v = 1'b0;

        run_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0,        32'h80FF_FF00, 1); // LB
        run_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_1234, 32'hDEAD_BEEF, 3); // SH
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0,        32'h0,         1); // LW misaligned
        run_op(1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        32'h0,         1); // read+write
        run_op(1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,        32'h0,         1); // size 3
        run_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0011, 32'h0,        32'h0,         1); // SH odd
        run_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_1001, 32'h0,        32'h1234_8056, 2); // LBU
        run_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0,        32'h8001_0000, 1); // LH
        run_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0,        32'h8001_0000, 1); // LHU
        run_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_5001, 32'h1234_56AB, 32'h0,        1); // SB
        run_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_5004, 32'hCAFE_F00D, 32'h0,        2); // SW
        run_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_1000, 32'h0,        32'h0000_007F, 1); // LB positive
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_7000, 32'h0,        32'h89AB_CDEF, 1); // LW
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'h0,        32'h1111_2222, 0); // never ready
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_6004, 32'h0,        32'h55AA_33CC, 4); // ready on last cycle

        // Reset while a load is in its second BUSY cycle
        v = 1'b1; rd = 1'b1; wr = 1'b0; sz = 2'd2; uns = 1'b0; addr_in = 32'h0000_4000;
        #1;
        check1("rb_issue_stall", stall_a, 1'b1);
        tick();
        v = 1'b0;
        #1;
        check1("rb_busy1_req", bus_a.dmem_req, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        check1("rb_busy2_req", bus_a.dmem_req, 1'b1);
        tick();
        check1("rb_req_a", bus_a.dmem_req, 1'b0);
        check1("rb_req_b", bus_b.dmem_req, 1'b0);
        check1("rb_stall", stall_a, 1'b0);
        check1("rb_wb_en", wb_en_a, 1'b1);
        check1("rb_timeout_exc", tmo_a, 1'b0);
        check1("rb_access_exc", acc_a, 1'b0);
        check32("rb_load_data_a", ld_out_a, 32'h0);
        check32("rb_load_data_b", ld_out_b, 32'h0);
        rst = 1'b0;
        ld_a = '0;
        ld_b = '0;
        tick();
        check1("rb_after_req", bus_a.dmem_req, 1'b0);
        check1("rb_after_timeout_exc", tmo_a, 1'b0);

        run_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0006, 32'h0,        32'h7FFE_0000, 2); // LH after reset
        check32("scoreboard_empty_a", 32'(q_a.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the MEM stage of the RV32 pipeline. It turns the load/store held in the EX/MEM register into a req/ready transaction on the data-memory port, stalls the upstream pipeline until the transaction completes, and drives the load-enable/bubble controls of the MEM/WB register. It also lane-aligns and extends load data, and flags illegal or timed-out accesses.

## Interface
- TIMEOUT_CYCLES, 255: maximum BUSY cycles waiting for `dmem_ready` before abort (1..65535).
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_mem_valid  in  1  EX/MEM holds a valid instruction.
- ex_mem_read / ex_mem_write  in  1 each  load / store.
- ex_mem_size  in  2  0 byte, 1 half, 2 word, 3 reserved.
- ex_mem_unsigned  in  1  zero-extend loads (LBU/LHU).
- ex_mem_addr  in  32  byte address; ex_mem_wdata  in  32  store data (low-aligned).
- dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32 (word-aligned); dmem_wdata  out  32; dmem_be  out  4.
- dmem_ready  in  1; dmem_rdata  in  32.
- stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- mem_wb_en  out  1  load MEM/WB register this cycle.
- mem_wb_bubble  out  1  force MEM/WB write_back to 0.
- load_data  out  32  aligned, extended load result.
- access_exc  out  1  one-cycle pulse: illegal access.
- timeout_exc  out  1  one-cycle pulse: transaction aborted.

## Operation
- States: IDLE, BUSY, DONE.
- Memory op = ex_mem_valid & (ex_mem_read | ex_mem_write).
- Illegal = both read and write, size 3, half with addr[0]=1, or word with addr[1:0]≠0.
- IDLE, no memory op: stall_out=0, mem_wb_en=1, mem_wb_bubble=0. Zero penalty.
- IDLE, illegal op: no request; access_exc=1, mem_wb_en=1, mem_wb_bubble=1, stall_out=0; stay IDLE.
- IDLE, legal op: stall_out=1, mem_wb_en=0; register dmem_addr={addr[31:2],2'b00}, dmem_we=write, dmem_be, dmem_wdata; next BUSY.
- dmem_be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111. Loads drive be as for stores.
- dmem_wdata: byte replicated in all 4 lanes; half replicated in both halves; word as-is.
- BUSY: dmem_req=1, with address, data, be and we held stable; stall_out=1; a 16-bit wait counter increments each cycle.
  - dmem_ready=1: capture load_data from dmem_rdata (select lane by addr[1:0], sign- or zero-extend per size/unsigned); next DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without ready: deassert request, set a timeout flag; next DONE.
- DONE: dmem_req=0, stall_out=0, mem_wb_en=1; mem_wb_bubble=1 and timeout_exc=1 if the timeout flag is set; next IDLE; counter and flag cleared.
- Stores complete the same way; load_data is unchanged on a store.
- dmem_ready outside BUSY is ignored.
- ex_mem_* inputs are sampled only in IDLE.

## Timing
- Reset values: state IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, load_data, counter = 0; access_exc, timeout_exc = 0. Combinational outputs follow IDLE with ex_mem_valid=0 (mem_wb_en=1, stall_out=0).
- Reset in BUSY: dmem_req=0 in the cycle after reset is sampled; no exception pulse.
- Legal access latency: op appears at cycle N (stall); BUSY from N+1; ready sampled at N+k; DONE at N+k+1, when MEM/WB loads and stall drops. Minimum 3 cycles (k=1).
- Ready and timeout in the same BUSY cycle: ready wins, no timeout_exc.
- stall_out, mem_wb_en, mem_wb_bubble, access_exc are combinational from state and ex_mem_*. timeout_exc and dmem_* are registered or state-decoded; no combinational path from dmem_ready to any output.
- Back-to-back memory ops: the second op enters IDLE in the cycle after DONE. Issue rate is at most one access per 3 cycles.

## Test plan
- ALU op (valid=1, read=write=0) for 4 cycles -> stall_out=0, mem_wb_en=1 every cycle, dmem_req never asserted.
- LB at addr 0x1003, dmem_rdata=0x80FF_FF00, ready on first BUSY cycle -> dmem_addr=0x1000, be=4'b1000, load_data=0xFFFF_FF80, stall_out high exactly 2 cycles.
- SH wdata=0x1234 at addr 0x2002, ready after 3 BUSY cycles -> dmem_we=1, be=4'b1100, wdata=0x1234_1234, inputs stable throughout BUSY, mem_wb_en only in DONE.
- LW at addr 0x3001 -> access_exc pulse, mem_wb_bubble=1, no dmem_req, no stall.
- TIMEOUT_CYCLES=4, LW with ready never asserted -> dmem_req high 4 cycles, then DONE with timeout_exc=1 and mem_wb_bubble=1; repeat with ready on the 4th cycle -> no timeout_exc.
- Reset asserted on the 2nd BUSY cycle -> dmem_req=0 next cycle, state IDLE, no exception pulses, load_data=0.
